// File: rtl/ifu_pf.sv
// rtl/ifu_pf.sv - prefetching instruction fetch unit with FQ_DEPTH-entry fetch queue and decode redirects
// Optional IFU_EXC_EN: flags misaligned/out-of-range redirect targets on exc_o and halts fetch.
module ifu_pf #(
   parameter int          ADDR_W   = 10,
   parameter int          FQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter string       IM_FILE  = "code.txt"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   input  logic        redir_i,
   input  logic [1:0]  redir_sel_i,
   input  logic [31:0] redir_pc_i,
   input  logic [25:0] redir_idx_i,
   input  logic [31:0] redir_reg_i,
   output logic        exc_o
);

   localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

   // Byte-wide image, loaded from IM_FILE by the surrounding environment.
   logic [7:0]    im_q [0:(1 << ADDR_W) - 1];

   logic [31:0]   fpc_q;
   logic [31:0]   rdata_q;
   logic [31:0]   rtag_q;
   logic          rv_q;
   logic [4:0]    cnt_q;
   logic [PW-1:0] hd_q;
   logic [PW-1:0] tl_q;
   logic [31:0]   qi_q [0:FQ_DEPTH-1];
   logic [31:0]   qp_q [0:FQ_DEPTH-1];

   logic          pop;
   logic          issue;
   logic [4:0]    occ;
   logic [31:0]   word;
   logic [31:0]   br_off;
   logic [31:0]   target;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign word = {im_q[{fpc_q[ADDR_W-1:2], 2'd0}], im_q[{fpc_q[ADDR_W-1:2], 2'd1}],
                  im_q[{fpc_q[ADDR_W-1:2], 2'd2}], im_q[{fpc_q[ADDR_W-1:2], 2'd3}]};

   assign br_off = {{14{redir_idx_i[15]}}, redir_idx_i[15:0], 2'b00};

   always_comb begin
      target = redir_reg_i;
      case (redir_sel_i)
         2'b00:   target = redir_pc_i + 32'd4 + br_off;
         2'b01:   target = {redir_pc_i[31:28], redir_idx_i, 2'b00};
         default: target = redir_reg_i;
      endcase
   end

   assign valid_o = (cnt_q != 5'd0);
   assign instr_o = qi_q[hd_q];
   assign pc_o    = qp_q[hd_q];
   assign pc4_o   = pc_o + 32'd4;
   assign pop     = valid_o & ready_i;
   // Slots already promised: queued entries plus the read in flight, less the one leaving now.
   assign occ     = cnt_q + {4'd0, rv_q} - {4'd0, pop};

`ifdef IFU_EXC_EN
   logic exc_q;
   logic bad;

   assign bad   = (target[1:0] != 2'b00) || (target[31:ADDR_W] != RESET_PC[31:ADDR_W]);
   assign issue = !redir_i && (occ < 5'(FQ_DEPTH)) && !exc_q;
   assign exc_o = exc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         exc_q <= 1'b0;
      end else if (redir_i) begin
         exc_q <= bad;
      end
   end
`else
   assign issue = !redir_i && (occ < 5'(FQ_DEPTH));
   assign exc_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc_q <= RESET_PC;
         rv_q  <= 1'b0;
         cnt_q <= 5'd0;
         hd_q  <= '0;
         tl_q  <= '0;
      end else if (redir_i) begin
         fpc_q <= {target[31:2], 2'b00};
         rv_q  <= 1'b0;
         cnt_q <= 5'd0;
         hd_q  <= '0;
         tl_q  <= '0;
      end else begin
         if (issue) begin
            rdata_q <= word;
            rtag_q  <= fpc_q;
            rv_q    <= 1'b1;
            fpc_q   <= fpc_q + 32'd4;
         end else begin
            rv_q    <= 1'b0;
         end
         if (rv_q) begin
            qi_q[tl_q] <= rdata_q;
            qp_q[tl_q] <= rtag_q;
            tl_q       <= ptr_nxt(tl_q);
         end
         if (pop) begin
            hd_q <= ptr_nxt(hd_q);
         end
         cnt_q <= cnt_q + {4'd0, rv_q} - {4'd0, pop};
      end
   end

endmodule
